// File: rtl/nand_reduce_pipe.sv
// -----------------------------------------------------------------------------
// nand_reduce_pipe
//
// Pipelined, multi-channel bitwise reduction. It replaces the fixed 10-input
// NAND macro. Each channel reduces its WIDTH-bit slice of A with a selectable
// operator (NAND/AND/NOR/OR/XOR/XNOR). A result can either cover a single beat
// or accumulate across a multi-beat frame that ends on LASTI.
//
// Pipeline:
//   stage 1 : per-channel group partials (GROUP bits each, last group padded
//             with the operator identity), plus the decoded frame mode
//   stage 2 : fold the partials into the per-channel accumulator; on the last
//             beat of a frame, present the (optionally inverted) result
//
// Ports:
//   CK     in   clock, rising edge
//   CDN    in   asynchronous active-low clear
//   A      in   CHANNELS*WIDTH operand bits, channel c at A[c*WIDTH +: WIDTH]
//   MODE   in   0 NAND, 1 AND, 2 NOR, 3 OR, 4 XOR, 5 XNOR, 6/7 illegal (NAND)
//   ACC    in   1 = accumulate beats until LASTI, 0 = single-beat frames
//   LASTI  in   final beat of a frame (only meaningful when ACC=1)
//   VI     in   input beat valid
//   RO     out  ready to upstream
//   ZN     out  CHANNELS-bit frame result
//   MERR   out  frame was started with an illegal MODE
//   VO     out  ZN/MERR valid
//   RI     in   downstream ready
// -----------------------------------------------------------------------------
module nand_reduce_pipe #(
  parameter int WIDTH    = 10,
  parameter int CHANNELS = 1,
  parameter int GROUP    = 4
) (
  input  logic                      CK,
  input  logic                      CDN,
  input  logic [CHANNELS*WIDTH-1:0] A,
  input  logic [2:0]                MODE,
  input  logic                      ACC,
  input  logic                      LASTI,
  input  logic                      VI,
  output logic                      RO,
  output logic [CHANNELS-1:0]       ZN,
  output logic                      MERR,
  output logic                      VO,
  input  logic                      RI
);

  localparam int P    = (WIDTH + GROUP - 1) / GROUP;
  localparam int PADW = P * GROUP;
  localparam int PADN = PADW - WIDTH;

  localparam logic [1:0] OP_AND = 2'd0;
  localparam logic [1:0] OP_OR  = 2'd1;
  localparam logic [1:0] OP_XOR = 2'd2;

  // Identity element of the base operator: 1 for AND, 0 for OR/XOR.
  function automatic logic ident(input logic [1:0] op);
    return (op == OP_AND);
  endfunction

  function automatic logic combine(input logic [1:0] op, input logic x,
                                   input logic y);
    logic r;
    case (op)
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      default: r = x ^ y;
    endcase
    return r;
  endfunction

  function automatic logic reduce_group(input logic [1:0] op,
                                        input logic [GROUP-1:0] bits);
    logic r;
    r = ident(op);
    for (int g = 0; g < GROUP; g++) r = combine(op, r, bits[g]);
    return r;
  endfunction

  function automatic logic reduce_parts(input logic [1:0] op,
                                        input logic [P-1:0] parts);
    logic r;
    r = ident(op);
    for (int p = 0; p < P; p++) r = combine(op, r, parts[p]);
    return r;
  endfunction

  // Returns {illegal, invert, base_op[1:0]}. Illegal codes behave as NAND.
  function automatic logic [3:0] decode_mode(input logic [2:0] m);
    logic [3:0] d;
    case (m)
      3'd0:    d = {1'b0, 1'b1, OP_AND};
      3'd1:    d = {1'b0, 1'b0, OP_AND};
      3'd2:    d = {1'b0, 1'b1, OP_OR};
      3'd3:    d = {1'b0, 1'b0, OP_OR};
      3'd4:    d = {1'b0, 1'b0, OP_XOR};
      3'd5:    d = {1'b0, 1'b1, OP_XOR};
      default: d = {1'b1, 1'b1, OP_AND};
    endcase
    return d;
  endfunction

  // Handshake and control.
  logic       run;
  logic       s1_v;
  logic       adv;
  logic       accept;
  logic       fire;
  logic       last_in;

  // Input-side frame tracking. It latches the mode on the first beat of a frame.
  logic       in_open;
  logic [1:0] in_op;
  logic       in_inv;
  logic       in_err;
  logic [3:0] dec;
  logic [1:0] cur_op;
  logic       cur_inv;
  logic       cur_err;

  logic                     pad_bit;
  logic [CHANNELS*PADW-1:0] a_pad;
  logic [CHANNELS*P-1:0]    part_d;

  logic [1:0]            s1_op;
  logic                  s1_inv;
  logic                  s1_err;
  logic                  s1_last;
  logic [CHANNELS*P-1:0] s1_part;

  logic                s2_open;
  logic [CHANNELS-1:0] acc;
  logic [CHANNELS-1:0] acc_new;

  assign adv     = !VO | RI;
  // run holds RO low until the first clock edge after reset release.
  assign RO      = run & (!s1_v | adv);
  assign accept  = VI & RO;
  assign fire    = s1_v & adv;
  assign last_in = LASTI | !ACC;

  assign dec     = decode_mode(MODE);
  assign cur_op  = in_open ? in_op  : dec[1:0];
  assign cur_inv = in_open ? in_inv : dec[2];
  assign cur_err = in_open ? in_err : dec[3];
  assign pad_bit = ident(cur_op);

  always_ff @(posedge CK or negedge CDN) begin
    if (!CDN) begin
      run <= 1'b0;
    end else begin
      run <= 1'b1;
    end
  end

  always_ff @(posedge CK or negedge CDN) begin
    if (!CDN) begin
      in_open <= 1'b0;
      in_op   <= OP_AND;
      in_inv  <= 1'b0;
      in_err  <= 1'b0;
    end else if (accept) begin
      in_open <= !last_in;
      in_op   <= cur_op;
      in_inv  <= cur_inv;
      in_err  <= cur_err;
    end
  end

  // Pad each channel to a whole number of groups with the operator identity.
  // Padding with the identity leaves the reduction result unchanged.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_pad
    if (PADN > 0) begin : g_fill
      assign a_pad[c*PADW +: PADW] = {{PADN{pad_bit}}, A[c*WIDTH +: WIDTH]};
    end else begin : g_exact
      assign a_pad[c*PADW +: PADW] = A[c*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    part_d = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      for (int p = 0; p < P; p++) begin
        part_d[c*P + p] = reduce_group(cur_op, a_pad[c*PADW + p*GROUP +: GROUP]);
      end
    end
  end

  // ---- stage 1: group partials, registered on accept ----
  always_ff @(posedge CK or negedge CDN) begin
    if (!CDN) begin
      s1_v    <= 1'b0;
      s1_op   <= OP_AND;
      s1_inv  <= 1'b0;
      s1_err  <= 1'b0;
      s1_last <= 1'b0;
    end else if (RO) begin
      s1_v <= VI;
      if (VI) begin
        s1_op   <= cur_op;
        s1_inv  <= cur_inv;
        s1_err  <= cur_err;
        s1_last <= last_in;
      end
    end
  end

  always_ff @(posedge CK) begin
    if (accept) s1_part <= part_d;
  end

  // The accumulator starts from the identity on the first beat of a frame.
  always_comb begin
    acc_new = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      acc_new[c] = combine(s1_op, s2_open ? acc[c] : ident(s1_op),
                           reduce_parts(s1_op, s1_part[c*P +: P]));
    end
  end

  // ---- stage 2: accumulate, present result on frame end ----
  always_ff @(posedge CK or negedge CDN) begin
    if (!CDN) begin
      s2_open <= 1'b0;
      acc     <= '0;
      VO      <= 1'b0;
      ZN      <= '0;
      MERR    <= 1'b0;
    end else begin
      if (fire && s1_last) begin
        // A new result overrides any consumption in the same cycle.
        ZN      <= acc_new ^ {CHANNELS{s1_inv}};
        MERR    <= s1_err;
        VO      <= 1'b1;
        acc     <= '0;
        s2_open <= 1'b0;
      end else begin
        if (fire) begin
          acc     <= acc_new;
          s2_open <= 1'b1;
        end
        if (RI) VO <= 1'b0;
      end
    end
  end

endmodule
